// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the dual-port register file: accepts ALU/LSU results in
// program order, drains up to two per cycle, and forwards queued data to operand fetch.
module regfile_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   alu_valid_i,
    output logic                   alu_ready_o,
    input  logic [4:0]             alu_rd_i,
    input  logic [XLEN-1:0]        alu_data_i,
    input  logic                   lsu_valid_i,
    output logic                   lsu_ready_o,
    input  logic [4:0]             lsu_rd_i,
    input  logic [XLEN-1:0]        lsu_data_i,
    input  logic                   wb_stall_i,
    output logic [4:0]             reg_addr1_o,
    output logic [4:0]             reg_addr2_o,
    output logic [XLEN-1:0]        wr_data1_o,
    output logic [XLEN-1:0]        wr_data2_o,
    output logic [1:0]             rdwr_config_o,
    input  logic [4:0]             q_rs1_i,
    input  logic [4:0]             q_rs2_i,
    output logic                   q_hit1_o,
    output logic                   q_hit2_o,
    output logic [XLEN-1:0]        q_data1_o,
    output logic [XLEN-1:0]        q_data2_o,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    ptr_t            head_q, head_d;
    ptr_t            tail_q, tail_d;
    cnt_t            count_q, count_d;

    cnt_t free;
    ptr_t head1;
    ptr_t lsu_slot;
    logic alu_push, lsu_push;
    logic wr_en1, wr_en2;
    cnt_t pushes, pops;

    assign free        = cnt_t'(DEPTH) - count_q;
    assign alu_ready_o = (free >= cnt_t'(1));
    assign lsu_ready_o = (free >= cnt_t'(2)) | ((free == cnt_t'(1)) & ~alu_valid_i);

    // x0 results complete the handshake but never occupy a slot.
    assign alu_push = alu_valid_i & alu_ready_o & (alu_rd_i != 5'd0);
    assign lsu_push = lsu_valid_i & lsu_ready_o & (lsu_rd_i != 5'd0);
    assign lsu_slot = tail_q + ptr_t'(alu_push);

    assign head1  = head_q + ptr_t'(1);
    assign wr_en1 = (count_q >= cnt_t'(1)) & ~wb_stall_i;
    // A same-rd pair drains one at a time so the younger value lands last.
    assign wr_en2 = (count_q >= cnt_t'(2)) & ~wb_stall_i & (rd_q[head_q] != rd_q[head1]);

    assign rdwr_config_o = {wr_en2, wr_en1};
    assign reg_addr1_o   = wr_en1 ? rd_q[head_q]   : 5'd0;
    assign wr_data1_o    = wr_en1 ? data_q[head_q] : '0;
    assign reg_addr2_o   = wr_en2 ? rd_q[head1]    : 5'd0;
    assign wr_data2_o    = wr_en2 ? data_q[head1]  : '0;
    assign occupancy_o   = count_q;

    assign pushes = cnt_t'(alu_push) + cnt_t'(lsu_push);
    assign pops   = cnt_t'(wr_en1) + cnt_t'(wr_en2);

    always_comb begin
        head_d  = head_q + ptr_t'(pops);
        tail_d  = tail_q + ptr_t'(pushes);
        count_d = count_q + pushes - pops;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= 5'd0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (alu_push) begin
                rd_q[tail_q]   <= alu_rd_i;
                data_q[tail_q] <= alu_data_i;
            end
            if (lsu_push) begin
                rd_q[lsu_slot]   <= lsu_rd_i;
                data_q[lsu_slot] <= lsu_data_i;
            end
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        ptr_t idx;
        idx       = head_q;
        q_hit1_o  = 1'b0;
        q_hit2_o  = 1'b0;
        q_data1_o = '0;
        q_data2_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + ptr_t'(i);
            if (cnt_t'(i) < count_q) begin
                if ((q_rs1_i != 5'd0) && (rd_q[idx] == q_rs1_i)) begin
                    q_hit1_o  = 1'b1;
                    q_data1_o = data_q[idx];
                end
                if ((q_rs2_i != 5'd0) && (rd_q[idx] == q_rs2_i)) begin
                    q_hit2_o  = 1'b1;
                    q_data2_o = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized bench for regfile_wb_queue checked against a queue-based model of the
// writeback buffer, plus directed sequences for the documented corner cases.
module tb_regfile_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid, alu_ready, lsu_valid, lsu_ready, wb_stall;
    logic [4:0]      alu_rd, lsu_rd, reg_addr1, reg_addr2, q_rs1, q_rs2;
    logic [XLEN-1:0] alu_data, lsu_data, wr_data1, wr_data2, q_data1, q_data2;
    logic [1:0]      rdwr_config;
    logic            q_hit1, q_hit2;
    logic [2:0]      occupancy;

    regfile_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .alu_valid_i  (alu_valid),
        .alu_ready_o  (alu_ready),
        .alu_rd_i     (alu_rd),
        .alu_data_i   (alu_data),
        .lsu_valid_i  (lsu_valid),
        .lsu_ready_o  (lsu_ready),
        .lsu_rd_i     (lsu_rd),
        .lsu_data_i   (lsu_data),
        .wb_stall_i   (wb_stall),
        .reg_addr1_o  (reg_addr1),
        .reg_addr2_o  (reg_addr2),
        .wr_data1_o   (wr_data1),
        .wr_data2_o   (wr_data2),
        .rdwr_config_o(rdwr_config),
        .q_rs1_i      (q_rs1),
        .q_rs2_i      (q_rs2),
        .q_hit1_o     (q_hit1),
        .q_hit2_o     (q_hit2),
        .q_data1_o    (q_data1),
        .q_data2_o    (q_data2),
        .occupancy_o  (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            model_q[$];
    logic [XLEN-1:0] regs[32];
    int              checks = 0;
    int              failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic lookup(input logic [4:0] rs, output logic hit, output logic [XLEN-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (rs != 5'd0) begin
            foreach (model_q[i]) begin
                if (model_q[i].rd == rs) begin
                    hit = 1'b1;
                    d   = model_q[i].data;
                end
            end
        end
    endtask

    // Called just after a rising edge: drive, check the cycle, advance model, cross edge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                        input logic stall, input logic [4:0] rs1, input logic [4:0] rs2);
        int              n;
        logic            e_ar, e_lr, e1, e2, h1, h2;
        logic [XLEN-1:0] d1, d2;
        alu_valid = av;  alu_rd = ard;  alu_data = ad;
        lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ld;
        wb_stall  = stall;
        q_rs1     = rs1; q_rs2 = rs2;
        #1;
        n    = model_q.size();
        e_ar = (n < DEPTH);
        e_lr = (n <= DEPTH - 2) || ((n == DEPTH - 1) && !av);
        e1   = (n >= 1) && !stall;
        e2   = (n >= 2) && !stall && (model_q[0].rd != model_q[1].rd);
        lookup(rs1, h1, d1);
        lookup(rs2, h2, d2);
        check_eq("occupancy", 64'(occupancy), 64'(n));
        check_eq("alu_ready", 64'(alu_ready), 64'(e_ar));
        check_eq("lsu_ready", 64'(lsu_ready), 64'(e_lr));
        check_eq("rdwr_config", 64'(rdwr_config), 64'({e2, e1}));
        check_eq("reg_addr1", 64'(reg_addr1), e1 ? 64'(model_q[0].rd) : 64'd0);
        check_eq("wr_data1", 64'(wr_data1), e1 ? 64'(model_q[0].data) : 64'd0);
        check_eq("reg_addr2", 64'(reg_addr2), e2 ? 64'(model_q[1].rd) : 64'd0);
        check_eq("wr_data2", 64'(wr_data2), e2 ? 64'(model_q[1].data) : 64'd0);
        check_eq("q_hit1", 64'(q_hit1), 64'(h1));
        check_eq("q_data1", 64'(q_data1), 64'(d1));
        check_eq("q_hit2", 64'(q_hit2), 64'(h2));
        check_eq("q_data2", 64'(q_data2), 64'(d2));
        if (e1) regs[model_q[0].rd] = model_q[0].data;
        if (e2) regs[model_q[1].rd] = model_q[1].data;
        if (e1) void'(model_q.pop_front());
        if (e2) void'(model_q.pop_front());
        if (av && e_ar && ard != 5'd0) model_q.push_back('{rd: ard, data: ad});
        if (lv && e_lr && lrd != 5'd0) model_q.push_back('{rd: lrd, data: ld});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic stall, input logic [4:0] rs1);
        step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, stall, rs1, 5'd0);
    endtask

    function automatic logic [4:0] rand_rd();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
    endfunction

    initial begin
        foreach (regs[i]) regs[i] = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        wb_stall = 1'b0; q_rs1 = '0; q_rs2 = '0;
        rst_n = 1'b0;
        #12;
        check_eq("rst_occupancy", 64'(occupancy), 64'd0);
        check_eq("rst_rdwr_config", 64'(rdwr_config), 64'd0);
        check_eq("rst_reg_addr1", 64'(reg_addr1), 64'd0);
        check_eq("rst_wr_data2", 64'(wr_data2), 64'd0);
        check_eq("rst_q_hit1", 64'(q_hit1), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ALU result drains the next cycle.
        step(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, '0, 1'b0, 5'd5, 5'd0);
        idle(1'b0, 5'd5);
        idle(1'b0, 5'd5);
        // Paired ALU+LSU drain on both ports.
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd1, 5'd2);
        idle(1'b0, 5'd2);
        idle(1'b0, 5'd0);
        // Same rd back-to-back, held so both are queued for the lookup.
        step(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd0);
        step(1'b1, 5'd3, 32'h2, 1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd0);
        idle(1'b1, 5'd3);
        idle(1'b0, 5'd3);
        idle(1'b0, 5'd3);
        idle(1'b0, 5'd3);
        check_eq("final_x3", 64'(regs[3]), 64'h2);
        // x0 result is accepted and dropped.
        step(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);
        idle(1'b0, 5'd0);
        // Fill under stall, then release.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 5'(i + 8), 32'(i * 32'h101), 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd12);
        end
        step(1'b1, 5'd20, 32'hDEAD, 1'b1, 5'd21, 32'hBEEF, 1'b1, 5'd10, 5'd11);
        for (int i = 0; i < 4; i++) idle(1'b0, 5'd12);

        // Asynchronous reset with three queued entries.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'(i + 1), 32'(32'hC0 + i), 1'b0, 5'd0, '0, 1'b1, 5'd1, 5'd0);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0; wb_stall = 1'b0; q_rs1 = 5'd2;
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_occupancy", 64'(occupancy), 64'd0);
        check_eq("async_rdwr_config", 64'(rdwr_config), 64'd0);
        check_eq("async_q_hit1", 64'(q_hit1), 64'd0);
        model_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b0, 5'd2);
        idle(1'b0, 5'd1);

        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 1) == 1, rand_rd(), $urandom(),
                 $urandom_range(0, 1) == 1, rand_rd(), $urandom(),
                 $urandom_range(0, 3) == 0, rand_rd(), rand_rd());
        end
        for (int c = 0; c < 6; c++) idle(1'b0, 5'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
